pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_reg.sv | 131 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid pipeline register.
package pipe_pkg;

  // Occupancy-coded state: EMPTY holds nothing, ONE holds main, FULL holds main + skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

  // Number of held entries for a given state
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register between pipeline stages.
// The main register drives the outputs and the skid register catches the
// one extra entry that arrives while downstream stalls. Because in_ready is
// decoded from registered state only, there is no combinational path from
// out_ready back to in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = 8,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;

  logic accept;
  logic consume;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = occ_of(state_q);
  // A bubble must never carry side-effect control bits downstream
  assign out_ctrl  = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};
  assign out_data  = main_data_q;
  assign out_pc    = main_pc_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Next-state and register-load decisions; flush overrides accept and consume
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      // Payload stays put; only the state forgets the entries
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (accept && consume) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
          end else if (consume) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (consume) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and entry registers with synchronous reset (reset beats flush)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      main_pc_q   <= PC_RESET;
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_pc_q   <= {PC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, a streaming
// sequence, and a randomized run checked against a queue-based model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data, in_pc, out_pc;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, fl, ordy;
    logic [7:0]  ictrl;
    logic [31:0] idata, ipc;
    logic        ev, erdy;
    logic [1:0]  eocc;
    logic [7:0]  ectrl;
    logic [31:0] edata, epc;
  } vec_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] data, pc;
  } entry_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic rst, logic iv, logic fl, logic ordy,
                              logic [7:0] ictrl, logic [31:0] idata, logic [31:0] ipc,
                              logic ev, logic erdy, logic [1:0] eocc,
                              logic [7:0] ectrl, logic [31:0] edata, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy;
    v.ictrl = ictrl; v.idata = idata; v.ipc = ipc;
    v.ev = ev; v.erdy = erdy; v.eocc = eocc;
    v.ectrl = ectrl; v.edata = edata; v.epc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic ev, input logic erdy,
                       input logic [1:0] eocc, input logic [7:0] ectrl,
                       input logic [31:0] edata, input logic [31:0] epc);
    checks++;
    if (out_valid !== ev || in_ready !== erdy || occupancy !== eocc ||
        out_ctrl !== ectrl || out_data !== edata || out_pc !== epc) begin
      failures++;
      $display("FAIL %s: got v=%0b rdy=%0b occ=%0d ctrl=%h data=%h pc=%h, want v=%0b rdy=%0b occ=%0d ctrl=%h data=%h pc=%h",
               name, out_valid, in_ready, occupancy, out_ctrl, out_data, out_pc,
               ev, erdy, eocc, ectrl, edata, epc);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic fl, input logic ordy,
                       input logic [7:0] ictrl, input logic [31:0] idata, input logic [31:0] ipc);
    reset = rst; in_valid = iv; flush = fl; out_ready = ordy;
    in_ctrl = ictrl; in_data = idata; in_pc = ipc;
  endtask

  entry_t q[$];
  entry_t last_head, exp_head, e;

  initial begin
    // rst iv fl ordy ctrl data pc | v rdy occ ctrl data pc
    vecs[0]  = mk(1,0,0,0, 8'h00, 32'h0,  32'h0,   0,1,2'd0, 8'h00, 32'h0, 32'h8000_0000);
    vecs[1]  = mk(1,1,0,1, 8'h11, 32'h55, 32'h50,  0,1,2'd0, 8'h00, 32'h0, 32'h8000_0000);
    vecs[2]  = mk(0,1,0,0, 8'hFF, 32'hA,  32'h100, 1,1,2'd1, 8'hFF, 32'hA, 32'h100);
    vecs[3]  = mk(0,1,0,0, 8'h01, 32'hB,  32'h104, 1,0,2'd2, 8'hFF, 32'hA, 32'h100);
    vecs[4]  = mk(0,1,0,0, 8'h02, 32'hC,  32'h108, 1,0,2'd2, 8'hFF, 32'hA, 32'h100);
    vecs[5]  = mk(0,1,0,1, 8'h02, 32'hC,  32'h108, 1,1,2'd1, 8'h01, 32'hB, 32'h104);
    vecs[6]  = mk(0,1,0,1, 8'h02, 32'hC,  32'h108, 1,1,2'd1, 8'h02, 32'hC, 32'h108);
    vecs[7]  = mk(0,0,0,1, 8'h77, 32'h99, 32'h999, 0,1,2'd0, 8'h00, 32'hC, 32'h108);
    vecs[8]  = mk(0,1,0,0, 8'hFF, 32'hD,  32'h10C, 1,1,2'd1, 8'hFF, 32'hD, 32'h10C);
    vecs[9]  = mk(0,0,0,1, 8'hFF, 32'h0,  32'h0,   0,1,2'd0, 8'h00, 32'hD, 32'h10C);
    vecs[10] = mk(0,1,0,0, 8'h03, 32'hE,  32'h110, 1,1,2'd1, 8'h03, 32'hE, 32'h110);
    vecs[11] = mk(0,1,0,0, 8'h04, 32'hF,  32'h114, 1,0,2'd2, 8'h03, 32'hE, 32'h110);
    vecs[12] = mk(0,1,1,1, 8'h06, 32'h10, 32'h118, 0,1,2'd0, 8'h00, 32'hE, 32'h110);
    vecs[13] = mk(0,0,0,1, 8'h00, 32'h0,  32'h0,   0,1,2'd0, 8'h00, 32'hE, 32'h110);
    vecs[14] = mk(0,1,1,1, 8'h07, 32'h11, 32'h11C, 0,1,2'd0, 8'h00, 32'hE, 32'h110);
    vecs[15] = mk(0,1,0,0, 8'h05, 32'h12, 32'h120, 1,1,2'd1, 8'h05, 32'h12, 32'h120);
    vecs[16] = mk(1,1,1,0, 8'h08, 32'h13, 32'h124, 0,1,2'd0, 8'h00, 32'h0, 32'h8000_0000);
    vecs[17] = mk(0,0,0,0, 8'h00, 32'h0,  32'h0,   0,1,2'd0, 8'h00, 32'h0, 32'h8000_0000);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Directed vectors: reset, stall/order, bubble, flush, reset-beats-flush
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].fl, vecs[i].ordy,
            vecs[i].ictrl, vecs[i].idata, vecs[i].ipc);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].eocc,
            vecs[i].ectrl, vecs[i].edata, vecs[i].epc);
    end

    // Streaming 1..8 with out_ready held high: one-cycle latency, no stalls
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h20 + 8'(i), 32'(i), 32'h200 + 32'(4*i));
      @(posedge clk); #1;
      check($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'h20 + 8'(i), 32'(i), 32'h200 + 32'(4*i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("stream_drain", 1'b0, 1'b1, 2'd0, 8'h00, 32'd8, 32'h220);

    // Randomized traffic against a two-deep FIFO model with occasional flush
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    @(posedge clk); #1;
    q.delete();
    last_head.ctrl = 8'h00; last_head.data = 32'h0; last_head.pc = 32'h8000_0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic iv, ordy, fl;
      logic [1:0] sz;
      iv   = ($urandom_range(99) < 70);
      ordy = ($urandom_range(99) < 60);
      fl   = ($urandom_range(99) < 2);
      e.ctrl = 8'($urandom);
      e.data = 32'(cyc + 1000);
      e.pc   = $urandom;
      drive(1'b0, iv, fl, ordy, e.ctrl, e.data, e.pc);
      sz = 2'(q.size());
      if (fl) begin
        q.delete();
      end else begin
        if (sz != 2'd0 && ordy) void'(q.pop_front());
        if (iv && sz != 2'd2) q.push_back(e);
      end
      if (q.size() > 0) last_head = q[0];
      @(posedge clk); #1;
      exp_head = last_head;
      check($sformatf("rand%0d", cyc), q.size() > 0, q.size() < 2, 2'(q.size()),
            (q.size() > 0) ? exp_head.ctrl : 8'h00, exp_head.data, exp_head.pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
